// File: rtl/wb_cam_dma.sv
// Wishbone DMA master: triggers a camera capture, reads pixels one by one and packs
// four per big-endian word into a linear frame buffer. Optional ack watchdog: WB_CAM_DMA_TIMEOUT_EN.
module wb_cam_dma #(
    parameter logic [31:0] CAM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter int          PIXEL_COUNT    = 19200,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_TRIG1, S_TRIG0, S_LEER1, S_RD, S_LEER0, S_MEMWR, S_GAP, S_FIN
    } state_t;

    localparam logic [20:0] PIX_TOTAL = 21'(PIXEL_COUNT);

    state_t      state_reg, state_next;
    state_t      ret_reg, ret_next;
    logic [31:0] pack_reg, pack_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [20:0] pix_cnt_reg, pix_cnt_next;
    logic [21:0] offset_reg, offset_next;
    logic        err_reg, err_next;
    logic        unused_bits;

`ifdef WB_CAM_DMA_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;
    assign unused_bits = ^wb_dat_i[31:8];
`else
    assign unused_bits = ^{wb_dat_i[31:8], TIMEOUT_CYCLES[0]};
`endif

    assign wb_sel_o = 4'hF;
    assign wb_stb_o = wb_cyc_o;
    assign busy     = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done     = (state_reg == S_FIN);
    assign err      = err_reg;

    always_comb begin
        state_next    = state_reg;
        ret_next      = ret_reg;
        pack_next     = pack_reg;
        byte_idx_next = byte_idx_reg;
        pix_cnt_next  = pix_cnt_reg;
        offset_next   = offset_reg;
        err_next      = err_reg;
        wb_cyc_o      = 1'b0;
        wb_we_o       = 1'b0;
        wb_adr_o      = 32'h0;
        wb_dat_o      = 32'h0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_TRIG1;
                    pack_next     = 32'h0;
                    byte_idx_next = 2'd0;
                    pix_cnt_next  = 21'd0;
                    offset_next   = 22'd0;
                    err_next      = 1'b0;
                end
            end
            S_TRIG1: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = CAM_BASE + 32'd4;
                wb_dat_o = 32'd1;
                if (wb_ack_i) begin
                    ret_next   = S_TRIG0;
                    state_next = S_GAP;
                end
            end
            S_TRIG0: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = CAM_BASE + 32'd4;
                if (wb_ack_i) begin
                    ret_next   = S_LEER1;
                    state_next = S_GAP;
                end
            end
            S_LEER1: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = CAM_BASE + 32'd8;
                wb_dat_o = 32'd1;
                if (wb_ack_i) begin
                    ret_next   = S_RD;
                    state_next = S_GAP;
                end
            end
            S_RD: begin
                wb_cyc_o = 1'b1;
                wb_adr_o = CAM_BASE;
                if (wb_ack_i) begin
                    // First pixel of a word lands in the most significant byte
                    case (byte_idx_reg)
                        2'd0:    pack_next[31:24] = wb_dat_i[7:0];
                        2'd1:    pack_next[23:16] = wb_dat_i[7:0];
                        2'd2:    pack_next[15:8]  = wb_dat_i[7:0];
                        default: pack_next[7:0]   = wb_dat_i[7:0];
                    endcase
                    byte_idx_next = byte_idx_reg + 2'd1;
                    ret_next      = S_LEER0;
                    state_next    = S_GAP;
                end
            end
            S_LEER0: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = CAM_BASE + 32'd8;
                if (wb_ack_i) begin
                    pix_cnt_next = pix_cnt_reg + 21'd1;
                    if ((byte_idx_reg == 2'd0) || (pix_cnt_reg + 21'd1 == PIX_TOTAL))
                        ret_next = S_MEMWR;
                    else
                        ret_next = S_LEER1;
                    state_next = S_GAP;
                end
            end
            S_MEMWR: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = MEM_BASE + {10'd0, offset_reg};
                wb_dat_o = pack_reg;
                if (wb_ack_i) begin
                    offset_next   = offset_reg + 22'd4;
                    pack_next     = 32'h0;
                    byte_idx_next = 2'd0;
                    ret_next      = (pix_cnt_reg == PIX_TOTAL) ? S_FIN : S_LEER1;
                    state_next    = S_GAP;
                end
            end
            S_GAP:   state_next = ret_reg;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

`ifdef WB_CAM_DMA_TIMEOUT_EN
        tmo_cnt_next = (wb_cyc_o && !wb_ack_i) ? tmo_cnt_reg + 32'd1 : 32'd0;
        // Abort overrides whatever access state we are stuck in
        if (wb_cyc_o && !wb_ack_i && (tmo_cnt_reg == TMO_LAST)) begin
            tmo_cnt_next = 32'd0;
            err_next     = 1'b1;
            state_next   = S_FIN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            ret_reg      <= S_IDLE;
            pack_reg     <= 32'h0;
            byte_idx_reg <= 2'd0;
            pix_cnt_reg  <= 21'd0;
            offset_reg   <= 22'd0;
            err_reg      <= 1'b0;
`ifdef WB_CAM_DMA_TIMEOUT_EN
            tmo_cnt_reg  <= 32'd0;
`endif
        end else begin
            state_reg    <= state_next;
            ret_reg      <= ret_next;
            pack_reg     <= pack_next;
            byte_idx_reg <= byte_idx_next;
            pix_cnt_reg  <= pix_cnt_next;
            offset_reg   <= offset_next;
            err_reg      <= err_next;
`ifdef WB_CAM_DMA_TIMEOUT_EN
            tmo_cnt_reg  <= tmo_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_wb_cam_dma.sv
// Directed bench for wb_cam_dma: two instances (8 and 5 pixels) behind a camera/memory
// responder model with configurable ack delay; logs every bus transaction.
module tb_wb_cam_dma;

    localparam logic [31:0] CAM = 32'h0000_0000;
    localparam logic [31:0] MEM = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  busy, done, err, we, cyc, stb, ack_in;
    logic [1:0]  ack_r, rand_ack;
    logic [31:0] adr[2], dato[2], dati[2], rdat_r[2];
    logic [3:0]  sel[2];
    logic        rand_in = 1'b1;
    logic [31:0] rand_dat;

    int          dly_max = 0;
    int          wcnt[2], dly[2], rd_idx[2], leer1_n[2];
    logic [1:0]  blk = 2'b00;

    logic [31:0] l_adr[2][64];
    logic [31:0] l_dat[2][64];
    logic        l_we[2][64];
    int          l_n[2];

    logic [1:0]  p_stb, p_ack, p_we;
    logic [31:0] p_adr[2], p_dat[2];
    int          gap_viol, hold_viol;
    int          done_cnt[2], run[2], last_run[2];

    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign ack_in[gi] = rand_in ? rand_ack[gi] : ack_r[gi];
        assign dati[gi]   = rand_in ? rand_dat : rdat_r[gi];

        wb_cam_dma #(
            .CAM_BASE(CAM), .MEM_BASE(MEM),
            .PIXEL_COUNT((gi == 0) ? 8 : 5), .TIMEOUT_CYCLES(16)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[gi]),
            .busy(busy[gi]), .done(done[gi]), .err(err[gi]),
            .wb_adr_o(adr[gi]), .wb_dat_o(dato[gi]), .wb_dat_i(dati[gi]),
            .wb_we_o(we[gi]), .wb_sel_o(sel[gi]), .wb_cyc_o(cyc[gi]),
            .wb_stb_o(stb[gi]), .wb_ack_i(ack_in[gi])
        );
    end

    // Camera + memory responder: registered ack after 0..dly_max wait cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r <= 2'b00;
            for (int i = 0; i < 2; i++) wcnt[i] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ack_r[i]) begin
                    ack_r[i] <= 1'b0;
                    wcnt[i]  <= 0;
                    dly[i]   <= int'($urandom_range(dly_max, 0));
                end else if (stb[i]) begin
                    if (blk[i] && we[i] && adr[i] == CAM + 32'd8 && dato[i] == 32'd1 && leer1_n[i] == 1) begin
                        wcnt[i] <= wcnt[i];
                    end else if (wcnt[i] >= dly[i]) begin
                        ack_r[i] <= 1'b1;
                        if (l_n[i] < 64) begin
                            l_adr[i][l_n[i]] <= adr[i];
                            l_dat[i][l_n[i]] <= dato[i];
                            l_we[i][l_n[i]]  <= we[i];
                            l_n[i]           <= l_n[i] + 1;
                        end
                        $display("[%0t] dut%0d %s adr=%08h dat=%08h", $time, i,
                                 we[i] ? "WR" : "RD", adr[i], dato[i]);
                        if (we[i] && adr[i] == CAM + 32'd4 && dato[i] == 32'd1) begin
                            rd_idx[i]  <= 0;
                            leer1_n[i] <= 0;
                        end
                        if (we[i] && adr[i] == CAM + 32'd8 && dato[i] == 32'd1)
                            leer1_n[i] <= leer1_n[i] + 1;
                        if (!we[i] && adr[i] == CAM) begin
                            rdat_r[i] <= {24'($urandom()), 8'((rd_idx[i] + 1) * 17)};
                            rd_idx[i] <= rd_idx[i] + 1;
                        end
                    end else begin
                        wcnt[i] <= wcnt[i] + 1;
                    end
                end
            end
        end
    end

    // Bus-rule monitor, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (p_stb[i] && p_ack[i] && stb[i]) gap_viol++;
            if (p_stb[i] && !p_ack[i] && stb[i] &&
                (adr[i] != p_adr[i] || dato[i] != p_dat[i] || we[i] != p_we[i])) hold_viol++;
            if (done[i] === 1'b1) done_cnt[i]++;
            if (stb[i] === 1'b1) run[i]++;
            else begin
                if (run[i] > 0) last_run[i] = run[i];
                run[i] = 0;
            end
            p_stb[i] = stb[i];
            p_ack[i] = ack_in[i];
            p_we[i]  = we[i];
            p_adr[i] = adr[i];
            p_dat[i] = dato[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic run_frame(input int i, input bit poke, input logic exp_err);
        int dc0;
        int cnt;
        int n0;
        l_n[i] = 0;
        dc0 = done_cnt[i];
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        chk("busy_after_start", 32'(busy[i]), 32'd1);
        chk("err_cleared", 32'(err[i]), 32'd0);
        cnt = 0;
        while (done[i] !== 1'b1 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            start[i] = poke && (cnt == 40);
        end
        chk("frame_done", 32'(done[i]), 32'd1);
        chk("busy_in_done", 32'(busy[i]), 32'd0);
        chk("err_at_done", 32'(err[i]), 32'(exp_err));
        n0 = l_n[i];
        if (poke) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_done", 32'(busy[i]), 32'd0);
        chk("no_extra_xfer", 32'(l_n[i]), 32'(n0));
        chk("done_once", 32'(done_cnt[i] - dc0), 32'd1);
    endtask

    task automatic check_log(input int i, input int npix);
        logic [31:0] ea[64];
        logic [31:0] ed[64];
        logic        ew[64];
        int          n;
        logic [31:0] word;
        logic [31:0] off;
        n = 0; word = 32'h0; off = 32'h0;
        ea[n] = CAM + 32'd4; ew[n] = 1'b1; ed[n] = 32'd1; n++;
        ea[n] = CAM + 32'd4; ew[n] = 1'b1; ed[n] = 32'd0; n++;
        for (int p = 0; p < npix; p++) begin
            ea[n] = CAM + 32'd8; ew[n] = 1'b1; ed[n] = 32'd1; n++;
            ea[n] = CAM;         ew[n] = 1'b0; ed[n] = 32'd0; n++;
            ea[n] = CAM + 32'd8; ew[n] = 1'b1; ed[n] = 32'd0; n++;
            word = word | (32'(((p + 1) * 17) & 255) << (24 - 8 * (p % 4)));
            if ((p % 4) == 3 || p == npix - 1) begin
                ea[n] = MEM + off; ew[n] = 1'b1; ed[n] = word; n++;
                off = off + 32'd4;
                word = 32'h0;
            end
        end
        chk($sformatf("log_len%0d", i), 32'(l_n[i]), 32'(n));
        for (int k = 0; k < n && k < l_n[i]; k++) begin
            chk($sformatf("adr%0d_%0d", i, k), l_adr[i][k], ea[k]);
            chk($sformatf("we%0d_%0d", i, k), 32'(l_we[i][k]), 32'(ew[k]));
            if (ew[k]) chk($sformatf("dat%0d_%0d", i, k), l_dat[i][k], ed[k]);
        end
    endtask

    initial begin
        int cnt;
        // Reset with random bus inputs
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            rand_ack = 2'($urandom());
            rand_dat = $urandom();
            start    = 2'($urandom());
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("rst_ctl", {26'd0, busy[i], done[i], err[i], cyc[i], stb[i], we[i]}, 32'd0);
                chk("rst_adr", adr[i], 32'd0);
                chk("rst_dat", dato[i], 32'd0);
                chk("rst_sel", 32'(sel[i]), 32'hF);
            end
        end
        @(negedge clk);
        start   = 2'b00;
        rand_in = 1'b0;
        rst     = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (cyc != 2'b00 || stb != 2'b00) cnt++;
        end
        chk("idle_no_cyc", 32'(cnt), 32'd0);

        // Single-cycle ack, 8 and 5 pixels
        dly_max = 0;
        run_frame(0, 1'b0, 1'b0);
        check_log(0, 8);
        chk("mem8_w0_adr", l_adr[0][14], 32'h0000_1000);
        chk("mem8_w0_dat", l_dat[0][14], 32'h1122_3344);
        chk("mem8_w1_adr", l_adr[0][27], 32'h0000_1004);
        chk("mem8_w1_dat", l_dat[0][27], 32'h5566_7788);
        run_frame(1, 1'b0, 1'b0);
        check_log(1, 5);
        chk("mem5_w1_adr", l_adr[1][18], 32'h0000_1004);
        chk("mem5_w1_dat", l_dat[1][18], 32'h5500_0000);

        // Random ack delay plus starts mid-frame and in the done cycle
        dly_max = 7;
        run_frame(0, 1'b1, 1'b0);
        check_log(0, 8);
        chk("gap_rule", 32'(gap_viol), 32'd0);
        chk("hold_rule", 32'(hold_viol), 32'd0);

        // Reset during the read of pixel 3
        dly_max = 2;
        l_n[0] = 0;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        cnt = 0;
        while (!(stb[0] && !we[0] && adr[0] == CAM && rd_idx[0] == 2) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("reach_rd3", 32'(cnt < 2000), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_cyc", 32'(cyc[0]), 32'd0);
        chk("rst_mid_stb", 32'(stb[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        @(negedge clk) rst = 1'b1;
        dly_max = 0;
        run_frame(0, 1'b0, 1'b0);
        check_log(0, 8);

`ifdef WB_CAM_DMA_TIMEOUT_EN
        // Second LEER1 never acked
        blk[0] = 1'b1;
        run_frame(0, 1'b0, 1'b1);
        chk("tmo_stb_len", 32'(last_run[0]), 32'd16);
        chk("tmo_log_len", 32'(l_n[0]), 32'd5);
        cnt = 0;
        for (int k = 0; k < l_n[0]; k++) if (l_adr[0][k] >= MEM) cnt++;
        chk("tmo_no_memwr", 32'(cnt), 32'd0);
        blk[0] = 1'b0;
        run_frame(0, 1'b0, 1'b0);
        check_log(0, 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_cam_dma.md
Name: wb_cam_dma

Overview:
- Wishbone master (initiator) that drives the camera Wishbone responder and moves captured pixels into system memory without CPU involvement.
- On a start pulse it performs these steps in order:
  - Triggers a capture through the camera's takepicture register.
  - Reads the pixel data register once per pixel, strobing the leer register around each read.
  - Packs 4 pixels per 32-bit word.
  - Writes each word to a linear frame buffer.
- Sits between the LM32 control logic, which owns start/done, and the shared Wishbone bus.

Parameters:
- CAM_BASE, 32'h0000_0000, byte base address of the camera responder (data at +0x00, takepicture at +0x04, leer at +0x08).
- MEM_BASE, 32'h0000_0000, byte address of word 0 of the frame buffer; must be 4-byte aligned.
- PIXEL_COUNT, 19200, number of 8-bit pixels per frame; range 1..2^20.
- TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to capture one frame; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the frame is complete or aborted
- err  out  1  sticky abort flag; cleared by the next accepted start
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data; only bits [7:0] are used for pixel reads
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte select; always 4'hF
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0: busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o.
  - wb_sel_o goes to 4'hF.
  - The state machine returns to IDLE, and the pack register, byte index, pixel counter and address offset all clear.
  - Reset mid-transfer drops cyc/stb immediately; the camera's registers are not restored.
- Bus rules, applied to every access:
  - adr, we, dat_o and sel are driven together with cyc=stb=1 and held stable until ack is sampled high.
  - In the cycle after ack, cyc and stb must be 0 (one idle GAP cycle), because the responder issues a registered ack and needs stb low between accesses.
  - There are no bursts, and no back-to-back strobes.
- State machine; every access state waits for ack, then passes through GAP to the next state:
  - IDLE: on start, clear counters and err, set busy, go to TRIG1.
  - TRIG1: write 1 to CAM_BASE+4. Next: TRIG0.
  - TRIG0: write 0 to CAM_BASE+4. Next: LEER1.
  - LEER1: write 1 to CAM_BASE+8. Next: RD.
  - RD: read CAM_BASE+0 and capture wb_dat_i[7:0] on the ack cycle. Next: LEER0.
  - LEER0: write 0 to CAM_BASE+8. Then:
    - increment the pixel counter;
    - if the byte index wrapped to 0, or the last pixel was just read, go to MEMWR;
    - otherwise go to LEER1.
  - MEMWR: write the pack register to MEM_BASE+offset, then offset += 4 and clear the pack register. If the pixel count equals PIXEL_COUNT, go to FIN; otherwise go to LEER1.
  - FIN: busy=0, done=1 for one cycle, go to IDLE.
- Packing:
  - The first pixel of each word goes to bits [31:24], the second to [23:16], the third to [15:8], the fourth to [7:0] (big-endian, to match LM32 byte order).
  - A partial final word is written with the unfilled low bytes as 0.
- Widths: offset is 22 bits, the pixel counter is 21 bits, and wb_adr_o = MEM_BASE + offset (wrap modulo 2^32).
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - start while busy has no effect.

Optional Feature:
- Macro WB_CAM_DMA_TIMEOUT_EN.
- With the macro:
  - A counter runs while stb=1 and ack=0.
  - When the counter reaches TIMEOUT_CYCLES, cyc/stb drop, err=1, and the machine goes to FIN; done pulses and the data already written remains.
  - The counter clears on every ack.
- Without the macro: no counter exists, the master waits for ack indefinitely, and err stays 0.

Test Plan:
- Reset: with rst=0 and random bus inputs, all outputs are 0 except wb_sel_o=4'hF. Release rst, hold start=0 for 20 cycles -> no cyc/stb.
- PIXEL_COUNT=8, MEM_BASE=0x1000, camera model returns bytes 0x11..0x88 with ack 1 cycle after stb. Expected:
  - Bus order: writes 1 then 0 to +4, then 8 sequences of [write 1 to +8, read +0, write 0 to +8].
  - Memory writes 0x11223344 to 0x1000 and 0x55667788 to 0x1004.
  - done pulses once; err=0.
- PIXEL_COUNT=5 -> second word is 0x55000000 at MEM_BASE+4; exactly 2 memory writes occur.
- Ack delayed 0..7 random cycles on every access -> same data as the 8-pixel test; stb always low for ≥1 cycle between accesses; adr/dat stable while stb is high.
- start pulsed again mid-frame and in the done cycle -> ignored; total transfers unchanged. rst asserted during the RD of pixel 3 -> cyc/stb low in the same cycle; the next start restarts from TRIG1 with offset 0.
- With WB_CAM_DMA_TIMEOUT_EN and TIMEOUT_CYCLES=16: the camera model never acks the 2nd LEER1 -> stb drops after 16 cycles, err=1, done pulses, and no memory write is issued. A following start clears err.
